// File: rtl/perf_counter_mmio_if.sv
// Data-bus bundle (ce/we/addr/data) between the CPU load/store port and a
// memory-mapped responder. The data_o return path is combinational.
interface perf_counter_mmio_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, data_i, input data_o);
  modport slave  (input ce, we, addr, data_i, output data_o);
endinterface

// File: rtl/perf_counter_mmio.sv
// perf_counter_mmio: memory-mapped cycle / branch / taken-branch counters.
// The program arms, runs, reads and clears the counters over the data bus.
// The block also snoops the fetch port so that it can start and stop on a
// PC window.
// Optional feature macro: PERF_OVF_IRQ_EN adds the irq_o output and the
// CTRL[10:8] overflow IRQ enables.
module perf_counter_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  perf_counter_mmio_if.slave bus,
  input  logic               inst_ce_i,
  input  logic [31:0]        inst_addr_i,
  input  logic [31:0]        inst_i,
  input  logic               branch_taken_i
`ifdef PERF_OVF_IRQ_EN
  ,
  output logic               irq_o
`endif
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CYCLE  = 3'd2;
  localparam logic [2:0] OFF_BRANCH = 3'd3;
  localparam logic [2:0] OFF_TAKEN  = 3'd4;
  localparam logic [2:0] OFF_START  = 3'd5;
  localparam logic [2:0] OFF_STOP   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COUNTING = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t           state;
  logic             ctrl_run;
  logic             ctrl_auto;
  logic [2:0]       ctrl_irq_en;
  logic [2:0]       ovf;          // {tk, br, cyc}
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;
  logic [31:0]      start_pc;
  logic [31:0]      stop_pc;

  logic             hit;
  logic             wr;
  logic             rd;
  logic [2:0]       offset;
  logic             clear;
  logic             start_match;
  logic             stop_match;
  logic             is_branch;
  logic             count_en;
  logic             wr_cyc;
  logic             wr_br;
  logic             wr_tk;
  logic             cyc_inc;
  logic             br_inc;
  logic             tk_inc;
  logic [CNT_W:0]   cyc_nxt;
  logic [CNT_W:0]   br_nxt;
  logic [CNT_W:0]   tk_nxt;
  logic [2:0]       ovf_set;
  logic [2:0]       ovf_w1c;
  logic             unused_bits;

  // Increment with the carry out exposed; the carry marks a wrap from all-ones.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] v);
    return {1'b0, v} + (CNT_W+1)'(1);
  endfunction

  // Zero-extend a counter to the 32-bit bus.
  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  assign hit    = bus.ce && (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign wr     = hit && bus.we;
  assign rd     = hit && !bus.we;
  assign offset = bus.addr[4:2];
  assign clear  = wr && (offset == OFF_CTRL) && bus.data_i[2];

  assign start_match = inst_ce_i && (inst_addr_i == start_pc);
  assign stop_match  = inst_ce_i && (inst_addr_i == stop_pc);
  // JAL (opcode[6:2]=11011) and conditional branches (opcode[6:2]=11000).
  assign is_branch   = inst_ce_i && ((inst_i[6:2] == 5'b11011) || (inst_i[6:2] == 5'b11000));

  // The START_PC match cycle itself is counted, so counting is enabled
  // combinationally from ARMED. If auto has been dropped, the armed state is
  // cancelled and the match cycle is not counted.
  assign count_en = (state == ST_COUNTING) ||
                    ((state == ST_ARMED) && ctrl_auto && start_match);

  assign wr_cyc  = wr && (offset == OFF_CYCLE);
  assign wr_br   = wr && (offset == OFF_BRANCH);
  assign wr_tk   = wr && (offset == OFF_TAKEN);
  assign cyc_inc = count_en;
  assign br_inc  = count_en && is_branch;
  assign tk_inc  = count_en && branch_taken_i;
  assign cyc_nxt = cnt_step(cyc_cnt);
  assign br_nxt  = cnt_step(br_cnt);
  assign tk_nxt  = cnt_step(tk_cnt);

  // A bus write to a counter suppresses its increment, and therefore its
  // overflow, in that cycle.
  assign ovf_set = {tk_inc  && !wr_tk  && tk_nxt[CNT_W],
                    br_inc  && !wr_br  && br_nxt[CNT_W],
                    cyc_inc && !wr_cyc && cyc_nxt[CNT_W]};
  assign ovf_w1c = (wr && (offset == OFF_STATUS)) ? bus.data_i[6:4] : 3'b000;

  assign unused_bits = ^{bus.addr[1:0], inst_i[31:7], inst_i[1:0]};

  // Control state machine; the transitions see CTRL as already registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ctrl_auto)     state <= ST_ARMED;
          else if (ctrl_run) state <= ST_COUNTING;
        end
        ST_ARMED: begin
          if (!ctrl_auto)       state <= ST_IDLE;
          else if (start_match) state <= ST_COUNTING;
        end
        ST_COUNTING: begin
          if (!ctrl_auto && !ctrl_run)      state <= ST_IDLE;
          else if (ctrl_auto && stop_match) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!ctrl_auto) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counters and sticky overflow flags: clear beats a bus write, which beats an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      br_cnt  <= '0;
      tk_cnt  <= '0;
      ovf     <= 3'b000;
    end else if (clear) begin
      cyc_cnt <= '0;
      br_cnt  <= '0;
      tk_cnt  <= '0;
      ovf     <= 3'b000;
    end else begin
      if (wr_cyc)       cyc_cnt <= bus.data_i[CNT_W-1:0];
      else if (cyc_inc) cyc_cnt <= cyc_nxt[CNT_W-1:0];
      if (wr_br)        br_cnt  <= bus.data_i[CNT_W-1:0];
      else if (br_inc)  br_cnt  <= br_nxt[CNT_W-1:0];
      if (wr_tk)        tk_cnt  <= bus.data_i[CNT_W-1:0];
      else if (tk_inc)  tk_cnt  <= tk_nxt[CNT_W-1:0];
      // A new overflow wins over a simultaneous write-1-to-clear.
      ovf <= (ovf & ~ovf_w1c) | ovf_set;
    end
  end

  // CTRL mode bits and the START/STOP PC registers (clear leaves the PCs alone).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_run  <= 1'b0;
      ctrl_auto <= 1'b0;
      start_pc  <= 32'h0;
      stop_pc   <= 32'h0;
    end else begin
      if (wr && (offset == OFF_CTRL)) begin
        ctrl_run  <= bus.data_i[0];
        ctrl_auto <= bus.data_i[1];
      end
      if (wr && (offset == OFF_START)) start_pc <= bus.data_i;
      if (wr && (offset == OFF_STOP))  stop_pc  <= bus.data_i;
    end
  end

`ifdef PERF_OVF_IRQ_EN
  // IRQ enables and the registered overflow interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_irq_en <= 3'b000;
      irq_o       <= 1'b0;
    end else begin
      if (wr && (offset == OFF_CTRL)) ctrl_irq_en <= bus.data_i[10:8];
      irq_o <= |(ovf & ctrl_irq_en);
    end
  end
`else
  assign ctrl_irq_en = 3'b000;
`endif

  // Zero-latency read mux; anything other than a read hit returns 0.
  always_comb begin
    bus.data_o = 32'h0;
    if (rd) begin
      case (offset)
        OFF_CTRL:   bus.data_o = {21'b0, ctrl_irq_en, 6'b0, ctrl_auto, ctrl_run};
        OFF_STATUS: bus.data_o = {25'b0, ovf, 2'b0, state};
        OFF_CYCLE:  bus.data_o = zext(cyc_cnt);
        OFF_BRANCH: bus.data_o = zext(br_cnt);
        OFF_TAKEN:  bus.data_o = zext(tk_cnt);
        OFF_START:  bus.data_o = start_pc;
        OFF_STOP:   bus.data_o = stop_pc;
        default:    bus.data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Self-checking bench for perf_counter_mmio: directed scenarios plus a
// randomized run compared against a behavioural register-level model.
module tb_perf_counter_mmio;

  localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
  localparam longint      WRAP      = 64'd4294967296;
  localparam int S_IDLE = 0, S_ARMED = 1, S_COUNT = 2, S_DONE = 3;

  logic        clk;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic        branch_taken_i;
`ifdef PERF_OVF_IRQ_EN
  logic        irq_o;
`endif

  perf_counter_mmio_if bus();

  perf_counter_mmio #(.BASE_ADDR(BASE_ADDR), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .inst_ce_i      (inst_ce_i),
    .inst_addr_i    (inst_addr_i),
    .inst_i         (inst_i),
    .branch_taken_i (branch_taken_i)
`ifdef PERF_OVF_IRQ_EN
    ,
    .irq_o          (irq_o)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int          m_state;
  logic        m_run, m_auto, m_irq;
  logic [2:0]  m_ien, m_ovf;
  longint      m_cnt[3];        // 0 cycle, 1 branch, 2 taken
  logic [31:0] m_start, m_stop;

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_state = S_IDLE; m_run = 0; m_auto = 0; m_irq = 0; m_ien = 0; m_ovf = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0; m_start = 0; m_stop = 0;
  endfunction

  function automatic logic [31:0] model_rd(int off);
    case (off)
      0: return {21'b0, m_ien, 6'b0, m_auto, m_run};
      1: return {25'b0, m_ovf, 2'b0, 2'(m_state)};
      2: return 32'(m_cnt[0]);
      3: return 32'(m_cnt[1]);
      4: return 32'(m_cnt[2]);
      5: return m_start;
      6: return m_stop;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic w, clr, start_hit, stop_hit, is_br, cnt_on;
    logic [2:0] inc, new_ovf;
    int off, ns;
    w   = bus.ce && bus.we && (bus.addr[31:5] == BASE_ADDR[31:5]);
    off = int'(bus.addr[4:2]);
    clr = w && (off == 0) && bus.data_i[2];
    start_hit = inst_ce_i && (inst_addr_i == m_start);
    stop_hit  = inst_ce_i && (inst_addr_i == m_stop);
    is_br  = inst_ce_i && ((inst_i[6:2] == 5'b11011) || (inst_i[6:2] == 5'b11000));
    cnt_on = (m_state == S_COUNT) || (m_state == S_ARMED && m_auto && start_hit);
    inc    = {branch_taken_i, is_br, 1'b1} & {3{cnt_on}};
    m_irq  = |(m_ovf & m_ien);
    ns = m_state;
    case (m_state)
      S_IDLE:  if (m_auto) ns = S_ARMED; else if (m_run) ns = S_COUNT;
      S_ARMED: if (!m_auto) ns = S_IDLE; else if (start_hit) ns = S_COUNT;
      S_COUNT: if (!m_auto && !m_run) ns = S_IDLE; else if (m_auto && stop_hit) ns = S_DONE;
      default: if (!m_auto) ns = S_IDLE;
    endcase
    new_ovf = m_ovf;
    if (w && off == 1) new_ovf = new_ovf & ~bus.data_i[6:4];
    for (int i = 0; i < 3; i++) begin
      if (w && off == 2 + i) m_cnt[i] = longint'(bus.data_i);
      else if (inc[i]) begin
        if (m_cnt[i] + 1 == WRAP) begin m_cnt[i] = 0; new_ovf[i] = 1'b1; end
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    if (clr) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0; new_ovf = 3'b000; ns = S_IDLE;
    end
    m_ovf = new_ovf;
    m_state = ns;
    if (w && off == 0) begin
      m_run  = bus.data_i[0];
      m_auto = bus.data_i[1];
`ifdef PERF_OVF_IRQ_EN
      m_ien  = bus.data_i[10:8];
`endif
    end
    if (w && off == 5) m_start = bus.data_i;
    if (w && off == 6) m_stop  = bus.data_i;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(int off, logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = BASE_ADDR + 32'(off * 4); bus.data_i = d;
    tick();
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(int off, output logic [31:0] v);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = BASE_ADDR + 32'(off * 4);
    #1;
    v = bus.data_o;
    bus.ce = 1'b0;
  endtask

  task automatic fetch_idle();
    inst_ce_i = 1'b0; inst_addr_i = 32'h0; inst_i = 32'h0; branch_taken_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int o = 0; o < 8; o++) begin
      bus_read(o, v);
      n_total++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL reset_por off=%0h got=%h want=%h", o * 4, v, 32'h0); end
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    bus_write(0, 32'h1);
    tick();
    bus_write(2, 32'h55);
    bus_read(2, v);
    n_total++;
    if (v !== 32'h55) begin n_bad++; $display("FAIL reset_precount cycle got=%h want=%h", v, 32'h55); end
    bus_read(1, v);
    n_total++;
    if (v !== 32'h2) begin n_bad++; $display("FAIL reset_precount status got=%h want=%h", v, 32'h2); end
    #1 rst = 1'b0;
    for (int o = 0; o < 8; o++) begin
      bus_read(o, v);
      n_total++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL reset_async off=%0h got=%h want=%h", o * 4, v, 32'h0); end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    for (int o = 0; o < 8; o++) begin
      bus_read(o, v);
      n_total++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL reset_release off=%0h got=%h want=%h", o * 4, v, 32'h0); end
    end
  endtask

  task automatic test_manual();
    logic [31:0] v;
    bus_write(0, 32'h1);
    repeat (5) tick();
    bus_read(1, v);
    n_total++;
    if (v !== 32'h2) begin n_bad++; $display("FAIL manual_running status got=%h want=%h", v, 32'h2); end
    repeat (5) tick();
    bus_write(0, 32'h0);
    repeat (3) tick();
    bus_read(2, v);
    n_total++;
    if (v !== 32'd11) begin n_bad++; $display("FAIL manual_cycle got=%0d want=%0d", v, 11); end
    for (int o = 0; o < 8; o++) begin
      bus_read(o, v);
      n_total++;
      if (v !== model_rd(o)) begin n_bad++; $display("FAIL manual_model off=%0h got=%h want=%h", o * 4, v, model_rd(o)); end
    end
  endtask

  task automatic test_auto();
    logic [31:0] v;
    logic [31:0] exp[5];
    bus_write(0, 32'h4);
    bus_write(5, 32'h4);
    bus_write(6, 32'h164);
    bus_write(0, 32'h2);
    // Non-matching fetches while arming: nothing is counted.
    inst_ce_i = 1'b1; inst_addr_i = 32'h100; inst_i = 32'h63; branch_taken_i = 1'b1;
    tick();
    inst_addr_i = 32'h0;
    tick();
    for (int k = 0; k < 40; k++) begin
      inst_addr_i = (k == 0) ? 32'h4 : (k == 39) ? 32'h164 : 32'h200 + 32'(4 * k);
      inst_i = (k == 5) ? 32'h6F : (k == 12 || k == 30) ? 32'h63 : 32'h13;
      branch_taken_i = (k == 12 || k == 30);
      tick();
    end
    exp[0] = 32'd40; exp[1] = 32'd3; exp[2] = 32'd2; exp[3] = 32'h3; exp[4] = 32'h2;
    for (int pass = 0; pass < 2; pass++) begin
      bus_read(2, v); n_total++;
      if (v !== exp[0]) begin n_bad++; $display("FAIL auto_cycle pass=%0d got=%0d want=%0d", pass, v, exp[0]); end
      bus_read(3, v); n_total++;
      if (v !== exp[1]) begin n_bad++; $display("FAIL auto_branch pass=%0d got=%0d want=%0d", pass, v, exp[1]); end
      bus_read(4, v); n_total++;
      if (v !== exp[2]) begin n_bad++; $display("FAIL auto_taken pass=%0d got=%0d want=%0d", pass, v, exp[2]); end
      bus_read(1, v); n_total++;
      if (v !== exp[3]) begin n_bad++; $display("FAIL auto_status pass=%0d got=%h want=%h", pass, v, exp[3]); end
      // Further fetches, branches and taken pulses while DONE.
      for (int k = 0; k < 6; k++) begin
        inst_ce_i = 1'b1; inst_addr_i = (k % 2 == 0) ? 32'h4 : 32'h164;
        inst_i = (k % 2 == 0) ? 32'h6F : 32'h63; branch_taken_i = 1'b1;
        tick();
      end
      fetch_idle();
    end
    bus_read(0, v); n_total++;
    if (v !== exp[4]) begin n_bad++; $display("FAIL auto_ctrl got=%h want=%h", v, exp[4]); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    bus_write(0, 32'h4);
    bus_write(0, 32'h1);
    tick();
    bus_write(2, 32'hFFFF_FFFF);
    bus_read(2, v); n_total++;
    if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_load got=%h want=%h", v, 32'hFFFF_FFFF); end
    tick();
    bus_read(2, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL wrap_cycle got=%h want=%h", v, 32'h0); end
    bus_read(1, v); n_total++;
    if (v !== 32'h12) begin n_bad++; $display("FAIL wrap_status got=%h want=%h", v, 32'h12); end
    bus_write(4, 32'hFFFF_FFFF);
    branch_taken_i = 1'b1;
    bus_write(1, 32'h50);
    branch_taken_i = 1'b0;
    bus_read(1, v); n_total++;
    if (v !== 32'h42) begin n_bad++; $display("FAIL wrap_w1c_vs_ovf status got=%h want=%h", v, 32'h42); end
    bus_read(4, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL wrap_taken got=%h want=%h", v, 32'h0); end
    bus_write(0, 32'h0);
    tick();
    bus_write(1, 32'h40);
    bus_read(1, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL wrap_w1c status got=%h want=%h", v, 32'h0); end
    bus_read(2, v); n_total++;
    if (v !== model_rd(2)) begin n_bad++; $display("FAIL wrap_model_cycle got=%h want=%h", v, model_rd(2)); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    bus_write(0, 32'h1);
    tick();
    inst_ce_i = 1'b1; inst_addr_i = 32'h300; inst_i = 32'h63;
    bus_write(3, 32'h100);
    fetch_idle();
    bus_read(3, v); n_total++;
    if (v !== 32'h100) begin n_bad++; $display("FAIL simul_branch_write got=%h want=%h", v, 32'h100); end
    branch_taken_i = 1'b1;
    bus_write(0, 32'h4);
    branch_taken_i = 1'b0;
    bus_read(4, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL simul_clear_taken got=%h want=%h", v, 32'h0); end
    bus_read(1, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL simul_clear_status got=%h want=%h", v, 32'h0); end
    bus_read(2, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL simul_clear_cycle got=%h want=%h", v, 32'h0); end
    bus_read(0, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL simul_clear_ctrl got=%h want=%h", v, 32'h0); end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    bus_write(2, 32'h1234);
    bus_read(8, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL decode_outside_read got=%h want=%h", v, 32'h0); end
    bus_read(7, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL decode_unmapped_read got=%h want=%h", v, 32'h0); end
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = BASE_ADDR + 32'h8;
    #1;
    n_total++;
    if (bus.data_o !== 32'h0) begin n_bad++; $display("FAIL decode_ce_low_read got=%h want=%h", bus.data_o, 32'h0); end
    // Out-of-window write aliasing CTRL (would clear and run if decoded).
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = BASE_ADDR + 32'h20; bus.data_i = 32'hFFFF_FFFF;
    tick();
    bus.addr = BASE_ADDR + 32'h28;
    tick();
    bus.ce = 1'b0; bus.addr = BASE_ADDR + 32'h8; bus.data_i = 32'h0;
    tick();
    bus.we = 1'b0;
    bus_write(1, 32'h3);
    bus_read(2, v); n_total++;
    if (v !== 32'h1234) begin n_bad++; $display("FAIL decode_cycle_kept got=%h want=%h", v, 32'h1234); end
    bus_read(0, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL decode_ctrl_kept got=%h want=%h", v, 32'h0); end
    bus_read(1, v); n_total++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL decode_status_ro got=%h want=%h", v, 32'h0); end
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    int off;
    bus_write(5, 32'h40);
    bus_write(6, 32'h80);
    for (int c = 0; c < 480; c++) begin
      inst_ce_i = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       inst_addr_i = 32'h40;
        1:       inst_addr_i = 32'h80;
        default: inst_addr_i = 32'($urandom_range(0, 63)) << 2;
      endcase
      case ($urandom_range(0, 3))
        0:       inst_i = 32'h6F;
        1:       inst_i = 32'h63;
        2:       inst_i = 32'h13;
        default: inst_i = $urandom();
      endcase
      branch_taken_i = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        off = $urandom_range(0, 7);
        d = $urandom();
        if (off == 0) begin
          d = d & 32'h0000_0703;
          if ($urandom_range(0, 9) == 0) d[2] = 1'b1;
        end
        if (off == 5 || off == 6) d = ($urandom_range(0, 1) == 0) ? 32'h40 : 32'h80;
        if (off >= 2 && off <= 4 && $urandom_range(0, 1) == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        bus.addr = BASE_ADDR + 32'(off * 4);
        if ($urandom_range(0, 7) == 0) bus.addr = bus.addr ^ 32'h20;
        bus.ce = 1'b1; bus.we = 1'b1; bus.data_i = d;
      end
      tick();
      bus.ce = 1'b0; bus.we = 1'b0;
`ifdef PERF_OVF_IRQ_EN
      n_total++;
      if (irq_o !== m_irq) begin n_bad++; $display("FAIL rand_irq cyc=%0d got=%b want=%b", c, irq_o, m_irq); end
`endif
      if (c % 8 == 7) begin
        fetch_idle();
        for (int o = 0; o < 8; o++) begin
          bus_read(o, v);
          n_total++;
          if (v !== model_rd(o)) begin n_bad++; $display("FAIL rand_reg cyc=%0d off=%0h got=%h want=%h", c, o * 4, v, model_rd(o)); end
        end
      end
    end
    fetch_idle();
  endtask

  initial begin
    rst = 1'b0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.data_i = 32'h0;
    fetch_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_manual();
    test_auto();
    test_wrap();
    test_simultaneous();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_mmio.md
Name: perf_counter_mmio

Overview:
- Memory-mapped performance-counter responder on the CPU data bus (ce/we/addr/data).
- The program itself arms, runs, reads and clears the cycle, branch and taken-branch counters.
- Also snoops the instruction fetch port and the `branch_taken` strobe.
- Sits beside `data_mem` in the SoC; the top-level address decode routes hits in its 32-byte window to it.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; must be 32-byte aligned.
- CNT_W, 32, counter width (1..32); read data is zero-extended to 32 bits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  data-bus access valid.
- we  in  1  1 = write, 0 = read; qualified by ce.
- addr  in  32  byte address.
- data_i  in  32  write data.
- data_o  out  32  read data, combinational.
- inst_ce_i  in  1  fetch valid.
- inst_addr_i  in  32  fetch PC.
- inst_i  in  32  fetched instruction.
- branch_taken_i  in  1  core branch-taken strobe, one cycle per taken branch.

Behaviour:
- hit = ce && addr[31:5] == BASE_ADDR[31:5]; offset = addr[4:2].
- Read:
  - data_o is the selected register when hit && !we, else 32'h0; combinational, zero-latency, same as `data_mem`.
  - Unmapped offsets (0x1C) read 0.
- Write: on posedge when hit && we. Writes outside the window or to read-only fields are ignored.
- Register map:
  - 0x00 CTRL: [0] run (RW); [1] auto (RW); [2] clear (write-1 pulse, reads 0).
  - 0x04 STATUS: [1:0] state (RO); [4] cyc_ovf, [5] br_ovf, [6] tk_ovf (sticky, write-1-to-clear).
  - 0x08 CYCLE, 0x0C BRANCH, 0x10 TAKEN: counters, RW.
  - 0x14 START_PC, 0x18 STOP_PC: RW.
- Reset (rst=0, asynchronous):
  - All registers 0, state IDLE.
  - data_o driven from the registers, so reads return 0 during reset.
- State machine, state encoding 0..3:
  - IDLE(0): auto=1 -> ARMED; else run=1 -> COUNTING. auto has priority over run.
  - ARMED(1): inst_ce_i && inst_addr_i==START_PC -> COUNTING; the match cycle is counted. auto=0 -> IDLE.
  - COUNTING(2):
    - Auto mode: inst_ce_i && inst_addr_i==STOP_PC -> DONE; the match cycle is counted (inclusive).
    - Manual mode: run=0 -> IDLE.
    - Either mode: auto and run both 0 -> IDLE.
  - DONE(3): counters frozen. Exit to IDLE on clear, or when auto is written 0.
- Transitions use the CTRL value as registered (a write takes effect the cycle after it is written).
- Counting, only in cycles whose current state is COUNTING, or ARMED with a START_PC match:
  - CYCLE += 1 every cycle.
  - BRANCH += 1 when inst_ce_i && (inst_i[6:2]==5'b11011 || inst_i[6:2]==5'b11000).
  - TAKEN += 1 when branch_taken_i.
- Wrap-around: a counter at all-ones wraps to 0 and sets its sticky ovf bit in the same edge.
- Precedence per counter each edge, highest first: clear (->0, all ovf bits ->0, state -> IDLE) > bus write (value loaded, no increment that cycle) > increment.
- Reset mid-count: everything returns to reset values immediately; no partial state survives.
- STATUS W1C and an overflow on the same bit in the same edge: overflow wins (bit stays 1).

Optional Feature:
- Macro PERF_OVF_IRQ_EN.
- Defined:
  - Adds output irq_o (1 bit), registered = |(STATUS[6:4] & CTRL[10:8]); CTRL[10:8] are RW IRQ enables.
  - Reset 0; deasserts the cycle after the ovf bits are cleared.
- Undefined: no irq_o port; CTRL[10:8] read 0 and ignore writes.

Test Plan:
- Reset with rst=0 mid-COUNTING (CYCLE=0x55) -> all reads 0, STATUS state=0 immediately; after rst=1 still 0.
- Manual: write CTRL=0x1, hold 10 cycles, write CTRL=0x0 -> CYCLE reads 10 (+1 for the deassert-write latency cycle, exact value checked against model), state IDLE.
- Auto: START_PC=0x4, STOP_PC=0x164, CTRL=0x2; fetch stream with 3 JAL/branch encodings, 2 branch_taken pulses, 40 cycles inclusive -> BRANCH=3, TAKEN=2, CYCLE=40, state=3; further fetches leave the counters unchanged.
- Wrap: write CYCLE=0xFFFF_FFFF, run -> next read 0x0, cyc_ovf=1; write STATUS=0x10 -> cyc_ovf=0.
- Simultaneous: write BRANCH=0x100 in a cycle with a branch fetch -> 0x100. CTRL=0x4 with branch_taken_i=1 -> TAKEN=0, state IDLE.
- Decode: read addr BASE_ADDR+0x20, or with ce=0 -> data_o=0; write there -> no register changes.
